// File: rtl/line_refill_unit.sv
// line_refill_unit: fetches a missing cache line word by word over a req/ack memory port
// and hands the assembled line back to the cache as a single-cycle pulse.
module line_refill_unit #(
    parameter int unsigned ByteOffsetBits = 5
) (
    input  logic                                    clk_i,
    input  logic                                    rstn_i,
    input  logic                                    req_en_i,
    input  logic [31:0]                             req_addr_i,
    output logic                                    line_valid_o,
    output logic [32*((2**ByteOffsetBits)/4)-1:0]   line_data_o,
    output logic                                    busy_o,
    output logic                                    mem_req_o,
    output logic [31:0]                             mem_addr_o,
    input  logic                                    mem_ack_i,
    input  logic [31:0]                             mem_rdata_i
);
    localparam int unsigned NrWordsPerLine = (2**ByteOffsetBits) / 4;
    localparam int unsigned LineSize       = 32 * NrWordsPerLine;
    localparam int unsigned CntBits        = ByteOffsetBits - 2;

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;

    state_e                   state_q, state_d;
    logic [CntBits-1:0]       cnt_q, cnt_d;
    logic [31-ByteOffsetBits:0] base_q, base_d;
    logic                     abort_q, abort_d;
    logic [LineSize-1:0]      data_q, data_d;
    logic                     last;
    logic                     unused_addr;

    assign unused_addr = ^req_addr_i[ByteOffsetBits-1:0];
    assign last        = cnt_q == CntBits'(NrWordsPerLine - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        abort_d = abort_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (req_en_i) begin
                state_d = FETCH;
                base_d  = req_addr_i[31:ByteOffsetBits];
                cnt_d   = '0;
                abort_d = 1'b0;
            end
            FETCH: begin
                if (!req_en_i) abort_d = 1'b1;
                if (mem_ack_i) begin
                    for (int k = 0; k < NrWordsPerLine; k++)
                        if (cnt_q == CntBits'(k)) data_d[32*k +: 32] = mem_rdata_i;
                    // a cancelled fill still drains the line but never reports it
                    if (last) state_d = abort_q ? IDLE : RESP;
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            abort_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            abort_q <= abort_d;
            data_q  <= data_d;
        end
    end

    assign mem_req_o    = state_q == FETCH;
    assign mem_addr_o   = {base_q, cnt_q, 2'b00};
    assign line_valid_o = state_q == RESP;
    assign busy_o       = state_q != IDLE;
    assign line_data_o  = data_q;
endmodule

// File: tb/tb_line_refill_unit.sv
// tb_line_refill_unit: directed fills from a vector table plus hand sequences for abort, reset and idle acks.
module tb_line_refill_unit;
    logic         clk_i = 1'b0;
    logic         rstn_i, req_en_i, mem_ack_i;
    logic [31:0]  req_addr_i, mem_rdata_i, mem_addr_o;
    logic         line_valid_o, busy_o, mem_req_o;
    logic [255:0] line_data_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          gap;
        logic [31:0] dbase;
        bit          hold;
        bit          scramble;
        logic [31:0] exp_a0;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    line_refill_unit dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_en_i(req_en_i), .req_addr_i(req_addr_i),
        .line_valid_o(line_valid_o), .line_data_o(line_data_o), .busy_o(busy_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic chk_line(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic do_fill(input vec_t v);
        logic [255:0] exp_line;
        int words, wait_n, lat;
        for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = v.dbase + 32'(k);
        words = 0;
        wait_n = 0;
        lat = -1;
        req_en_i = 1'b1;
        req_addr_i = v.addr;
        mem_ack_i = 1'b0;
        for (int cyc = 1; cyc <= 300 && lat < 0; cyc++) begin
            @(negedge clk_i);
            if (v.scramble && words > 0) req_addr_i = ~v.addr;
            mem_ack_i = 1'b0;
            if (line_valid_o) begin
                lat = cyc;
                chk_line("line_data", line_data_o, exp_line);
                if (!v.hold) req_en_i = 1'b0;
            end else if (mem_req_o) begin
                chk32("mem_addr", mem_addr_o, v.exp_a0 + 32'(4 * words));
                wait_n++;
                if (wait_n == v.gap) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = v.dbase + 32'(words);
                    words++;
                    wait_n = 0;
                end
            end
        end
        chk32("latency", 32'(lat), 32'(v.exp_lat));
        chk32("acks", 32'(words), 32'd8);
        @(negedge clk_i);
        chk32("post_busy", 32'(busy_o), 32'd0);
        chk32("post_req", 32'(mem_req_o), 32'd0);
        chk32("post_valid", 32'(line_valid_o), 32'd0);
        req_en_i = 1'b0;
        @(negedge clk_i);
        chk32("idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int acks, pulses;
        vecs[0] = '{32'h0000_1234, 1, 32'h1000_0000, 1'b0, 1'b0, 32'h0000_1220, 9};
        vecs[1] = '{32'h0000_5678, 3, 32'hA5A5_0000, 1'b0, 1'b0, 32'h0000_5660, 25};
        vecs[2] = '{32'hFFFF_FFFF, 2, 32'hDEAD_0000, 1'b1, 1'b0, 32'hFFFF_FFE0, 17};
        vecs[3] = '{32'h0000_2000, 1, 32'h2222_0000, 1'b0, 1'b0, 32'h0000_2000, 9};
        vecs[4] = '{32'h0000_4000, 1, 32'h4444_0000, 1'b0, 1'b0, 32'h0000_4000, 9};
        vecs[5] = '{32'h8000_001F, 1, 32'h8888_0000, 1'b0, 1'b1, 32'h8000_0000, 9};

        rstn_i = 1'b0;
        req_en_i = 1'b0;
        req_addr_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        #12;
        chk32("rst_req", 32'(mem_req_o), 32'd0);
        chk32("rst_busy", 32'(busy_o), 32'd0);
        chk32("rst_valid", 32'(line_valid_o), 32'd0);
        chk32("rst_addr", mem_addr_o, 32'd0);
        chk_line("rst_data", line_data_o, 256'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 3; i++) do_fill(vecs[i]);

        // request withdrawn after word 2: line drains silently
        req_en_i = 1'b1;
        req_addr_i = 32'h0000_3000;
        acks = 0;
        pulses = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (line_valid_o) pulses++;
            if (mem_req_o) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'hC0DE_0000 + 32'(acks);
                acks++;
                if (acks == 3) req_en_i = 1'b0;
            end
        end
        chk32("abort_acks", 32'(acks), 32'd8);
        chk32("abort_pulses", 32'(pulses), 32'd0);
        chk32("abort_busy", 32'(busy_o), 32'd0);
        do_fill(vecs[3]);

        // reset while waiting on word 5
        req_en_i = 1'b1;
        req_addr_i = 32'h0000_4000;
        acks = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (mem_req_o && acks < 5) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'h5555_0000 + 32'(acks);
                acks++;
            end
        end
        chk32("wait_addr", mem_addr_o, 32'h0000_4014);
        chk32("wait_req", 32'(mem_req_o), 32'd1);
        chk32("wait_busy", 32'(busy_o), 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        chk32("arst_req", 32'(mem_req_o), 32'd0);
        chk32("arst_busy", 32'(busy_o), 32'd0);
        chk32("arst_valid", 32'(line_valid_o), 32'd0);
        chk32("arst_addr", mem_addr_o, 32'd0);
        chk_line("arst_data", line_data_o, 256'd0);
        req_en_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_fill(vecs[4]);

        // acks while idle must not start anything
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b1;
            mem_rdata_i = 32'hFFFF_FFFF;
            chk32("idle_ack_busy", 32'(busy_o), 32'd0);
            chk32("idle_ack_req", 32'(mem_req_o), 32'd0);
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk32("idle_ack_busy_end", 32'(busy_o), 32'd0);
        do_fill(vecs[5]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
